// File: rtl/alu_seq_exec.sv
// alu_seq_exec -- execute-stage ALU with a valid/ready front and back end.
//
// Purpose:
//   Consumes the 4-bit Operation code produced by ALU decode together with
//   operands SrcA/SrcB and produces ALUResult/BranchTaken. Logic, add/sub,
//   compare, branch and unknown ops complete one cycle after accept. Shifts
//   run iteratively one bit per cycle. busy is high while a shift is in
//   flight so the pipeline front end can stall.
//
// Configuration macro:
//   FAST_SHIFT_EN  when defined, shifts use a single-cycle barrel shifter,
//                  the SHIFT state is never entered and busy is tied low.
//                  When undefined (default) only the 1-bit/cycle shifter
//                  exists.
//
// Ports:
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous active-high reset
//   flush        in   1        synchronous abort of in-flight/held op
//   in_valid     in   1        Operation/SrcA/SrcB valid
//   in_ready     out  1        block can accept an op this cycle
//   Operation    in   4        op code
//   SrcA         in   DATA_W   operand A (rs1 / PC)
//   SrcB         in   DATA_W   operand B (rs2 / imm); shamt = SrcB[SHAMT_W-1:0]
//   out_valid    out  1        ALUResult/BranchTaken valid
//   out_ready    in   1        consumer takes result
//   ALUResult    out  DATA_W   result
//   BranchTaken  out  1        branch condition true (branch ops only)
//   busy         out  1        high while a shift is iterating

module alu_seq_exec #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              BranchTaken,
    output logic              busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b1111;

`ifdef FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                bt_q, bt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic                accept;
    logic [SHAMT_W-1:0]  shamt;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // One step of the iterative shifter; SRA replicates the sign bit.
    function automatic logic [DATA_W-1:0] shift_step(input logic [3:0]        op,
                                                     input logic [DATA_W-1:0] v);
        case (op)
            OP_SLL:  return {v[DATA_W-2:0], 1'b0};
            OP_SRL:  return {1'b0, v[DATA_W-1:1]};
            default: return {v[DATA_W-1], v[DATA_W-1:1]};
        endcase
    endfunction

    // Single-cycle result. In the default build shifts only reach this
    // function with shamt == 0, so they simply pass SrcA through.
    function automatic logic [DATA_W-1:0] alu_result(input logic [3:0]        op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
`ifdef FAST_SHIFT_EN
        logic [SHAMT_W-1:0]       sh;
        logic signed [DATA_W-1:0] sa;
        sh = b[SHAMT_W-1:0];
        sa = a;
`endif
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef FAST_SHIFT_EN
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return sa >>> sh;
`else
            OP_SLL,
            OP_SRL,
            OP_SRA:  return a;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [3:0]        op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
        case (op)
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return $signed(a) <  $signed(b);
            OP_BGE:  return $signed(a) >= $signed(b);
            default: return 1'b0;
        endcase
    endfunction

    assign shamt = SrcB[SHAMT_W-1:0];

    // A held result may be replaced in the same cycle the consumer takes it.
    // flush blocks acceptance outright.
    assign in_ready  = !flush && ((state_q == S_IDLE) ||
                                  ((state_q == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = res_q;
    assign BranchTaken = bt_q;

`ifdef FAST_SHIFT_EN
    assign busy = 1'b0;
`else
    assign busy = (state_q == S_SHIFT);
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        bt_d    = bt_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        case (state_q)
            S_SHIFT: begin
                acc_d = shift_step(op_q, acc_q);
                cnt_d = cnt_q - SHAMT_W'(1);
                // Last step: publish the final shifted value directly.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                    res_d   = shift_step(op_q, acc_q);
                    bt_d    = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // accept is only possible from IDLE or a draining DONE.
        if (accept) begin
            op_d = Operation;
            if (!FAST && is_shift(Operation) && (shamt != '0)) begin
                state_d = S_SHIFT;
                acc_d   = SrcA;
                cnt_d   = shamt;
            end else begin
                state_d = S_DONE;
                res_d   = alu_result(Operation, SrcA, SrcB);
                bt_d    = branch_taken(Operation, SrcA, SrcB);
            end
        end

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            bt_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            bt_q    <= bt_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec (DATA_W = 32). Expected values come
// from a behavioural model of the op table using plain arithmetic.

module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        BranchTaken;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_seq_exec #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Operation   (Operation),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .BranchTaken (BranchTaken),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sa;
        sh = b % 32;
        sa = a;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd7:    return a - b;
            4'd12:   return a ^ b;
            4'd15:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return a << sh;
            4'd4:    return a >> sh;
            4'd6:    return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_bt(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        case (op)
            4'd8:    return a == b;
            4'd9:    return a != b;
            4'd10:   return $signed(a) < $signed(b);
            4'd11:   return $signed(a) >= $signed(b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
        return 1;
`else
        if ((op == 4'd3 || op == 4'd4 || op == 4'd6) && (b % 32) != 0)
            return 1 + int'(b % 32);
        return 1;
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic idle(input int n);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Issue one op with out_ready high, scramble the operand inputs after
    // accept, then wait for the result and compare result, flag, latency
    // and the number of busy/in_ready-low cycles.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int cycles;
        int busy_cyc;
        int lat;
        lat = model_lat(op, b);
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %0b want 1", name, in_ready);
        else pass_cnt++;
        Operation = op; SrcA = a; SrcB = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        cycles = 1;
        busy_cyc = 0;
        while (!out_valid && cycles < 200) begin
            if (busy === 1'b1 && in_ready === 1'b0) busy_cyc++;
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles >= 200) $display("FAIL %s_timeout: out_valid never rose", name);
        total_cnt++;
        if (cycles !== lat) $display("FAIL %s_latency: got %0d want %0d", name, cycles, lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_cyc !== lat - 1) $display("FAIL %s_busy: got %0d want %0d", name, busy_cyc, lat - 1);
        else pass_cnt++;
        total_cnt++;
        if (ALUResult !== model_res(op, a, b))
            $display("FAIL %s_result: got %h want %h", name, ALUResult, model_res(op, a, b));
        else pass_cnt++;
        total_cnt++;
        if (BranchTaken !== model_bt(op, a, b))
            $display("FAIL %s_branch: got %0b want %0b", name, BranchTaken, model_bt(op, a, b));
        else pass_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
        #12;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_ctrl: got v=%0b b=%0b want 0 0", out_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (ALUResult !== 32'd0 || BranchTaken !== 1'b0) $display("FAIL reset_data: got %h/%0b want 0/0", ALUResult, BranchTaken);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        run_op("add_wrap", 4'b0010, 32'h7FFFFFFF, 32'h00000001);
        run_op("sra4",     4'b0110, 32'h80000000, 32'd4);
        run_op("sll_sh0",  4'b0011, 32'h12345678, 32'h00000020);
        run_op("srl31",    4'b0100, 32'h80000000, 32'd31);
        run_op("blt",      4'b1010, 32'hFFFFFFFF, 32'd1);
        run_op("bge",      4'b1011, 32'hFFFFFFFF, 32'd1);
        run_op("beq",      4'b1000, 32'd5, 32'd5);
        run_op("bne",      4'b1001, 32'd5, 32'd5);
        run_op("slt",      4'b1111, 32'hFFFFFFFF, 32'd1);
        run_op("sub_wrap", 4'b0111, 32'd0, 32'd1);
        run_op("illegal",  4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF);
    endtask

    task automatic test_back_to_back_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 1) == 1) b = {b[31:5], 5'($urandom_range(0, 6))};
            run_op("rand", op, a, b);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        idle(2);
        @(negedge clk);
        Operation = 4'b0010; SrcA = 32'h7FFFFFFF; SrcB = 32'h00000001;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        held = model_res(4'b0010, 32'h7FFFFFFF, 32'h00000001);
        total_cnt++;
        if (out_valid !== 1'b1 || ALUResult !== held)
            $display("FAIL bp_first: got v=%0b %h want 1 %h", out_valid, ALUResult, held);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || ALUResult !== held || BranchTaken !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL bp_hold: got v=%0b %h bt=%0b rdy=%0b want 1 %h 0 0",
                         out_valid, ALUResult, BranchTaken, in_ready, held);
            else pass_cnt++;
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        Operation = 4'b1100; SrcA = 32'hFF; SrcB = 32'h0F;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_same_cycle_ready: got %0b want 1", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || ALUResult !== model_res(4'b1100, 32'hFF, 32'h0F))
            $display("FAIL bp_xor: got v=%0b %h want 1 %h", out_valid, ALUResult,
                     model_res(4'b1100, 32'hFF, 32'h0F));
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int pulses;
        idle(2);
        @(negedge clk);
        Operation = 4'b0100; SrcA = 32'h80000000; SrcB = 32'd10;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; Operation = 4'b0010;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0b want 0", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_idle: got v=%0b b=%0b want 0 0", out_valid, busy);
        else pass_cnt++;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL flush_no_pulse: got %0d want 0", pulses);
        else pass_cnt++;
    endtask

    task automatic test_reset_midshift();
        int pulses;
        idle(2);
        @(negedge clk);
        Operation = 4'b0100; SrcA = 32'hFFFF0000; SrcB = 32'd10;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_mid_ctrl: got v=%0b b=%0b want 0 0", out_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (ALUResult !== 32'd0 || BranchTaken !== 1'b0)
            $display("FAIL rst_mid_data: got %h/%0b want 0/0", ALUResult, BranchTaken);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %0b want 1", in_ready);
        else pass_cnt++;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL rst_mid_no_pulse: got %0d want 0", pulses);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_random();
        test_backpressure();
        test_flush();
        test_reset_midshift();
        run_op("after_reset_add", 4'b0010, 32'd3, 32'd4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
